// File: rtl/i2c_edid_reader_ctrl.sv
// i2c_edid_reader_ctrl: initiator-side DDC/I2C sequencer that reads an EDID
// block from a sink and writes it into local RAM.
// A byte-level I2C engine is driven one command at a time: START, 0xA0, offset,
// repeated START, 0xA1, NUM_BYTES reads (NACK on the last), STOP.
// Optional feature macro: EDID_CHECKSUM_EN adds a modulo-256 checksum check of
// the received block, reported on checksum_ok.
`timescale 1ns/1ps

module i2c_edid_reader_ctrl #(
  parameter int unsigned NUM_BYTES = 128,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] base_offset,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic       cmd_write,
  output logic       cmd_read,
  output logic [7:0] tx_byte,
  output logic       ack_out,
  input  logic       cmd_done,
  input  logic [7:0] rx_byte,
  input  logic       line_ack,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       checksum_ok
);

  localparam logic [8:0] LastCnt  = 9'(NUM_BYTES - 1);
  localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);
  localparam logic [7:0] DevWrite = 8'hA0;
  localparam logic [7:0] DevRead  = 8'hA1;

  typedef enum logic [3:0] {
    StIdle, StStart, StDevW, StStopR, StOffs, StRStart, StDevR, StRead, StStop
  } state_e;

  state_e     state_q, state_d;
  // issued_q: command for the current state already pulsed, now waiting for cmd_done
  logic       issued_q, issued_d;
  logic [7:0] offset_q, offset_d;
  logic [8:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic       err_q, err_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       issue;
  logic       wait_done;

  assign issue     = (state_q != StIdle) && !issued_q;
  assign wait_done = issued_q && cmd_done;

`ifdef EDID_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       ok_q, ok_d;
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      issued_q    <= 1'b0;
      offset_q    <= 8'h00;
      cnt_q       <= 9'd0;
      retry_q     <= 4'd0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef EDID_CHECKSUM_EN
      sum_q       <= 8'h00;
      ok_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef EDID_CHECKSUM_EN
      sum_q       <= sum_d;
      ok_q        <= ok_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    offset_d    = offset_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
`ifdef EDID_CHECKSUM_EN
    sum_d       = sum_q;
    ok_d        = ok_q;
`endif

    if (issue) issued_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          offset_d = base_offset;
          cnt_d    = 9'd0;
          retry_d  = 4'd0;
          err_d    = 1'b0;
          issued_d = 1'b0;
          state_d  = StStart;
`ifdef EDID_CHECKSUM_EN
          sum_d    = 8'h00;
          ok_d     = 1'b0;
`endif
        end
      end
      StStart: begin
        if (wait_done) begin
          issued_d = 1'b0;
          state_d  = StDevW;
        end
      end
      StDevW: begin
        if (wait_done) begin
          issued_d = 1'b0;
          if (!line_ack) begin
            state_d = StOffs;
          end else if (retry_q < MaxRetry) begin
            retry_d = retry_q + 4'd1;
            state_d = StStopR;
          end else begin
            err_d   = 1'b1;
            state_d = StStop;
          end
        end
      end
      StStopR: begin
        if (wait_done) begin
          issued_d = 1'b0;
          state_d  = StStart;
        end
      end
      StOffs: begin
        if (wait_done) begin
          issued_d = 1'b0;
          err_d    = line_ack;
          state_d  = line_ack ? StStop : StRStart;
        end
      end
      StRStart: begin
        if (wait_done) begin
          issued_d = 1'b0;
          state_d  = StDevR;
        end
      end
      StDevR: begin
        if (wait_done) begin
          issued_d = 1'b0;
          err_d    = line_ack;
          state_d  = line_ack ? StStop : StRead;
        end
      end
      StRead: begin
        if (wait_done) begin
          // Re-arm for the next read, or move on after the last byte
          issued_d    = 1'b0;
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[7:0];
          mem_wdata_d = rx_byte;
          cnt_d       = cnt_q + 9'd1;
`ifdef EDID_CHECKSUM_EN
          sum_d       = sum_q + rx_byte;
`endif
          if (cnt_q == LastCnt) state_d = StStop;
        end
      end
      StStop: begin
        if (wait_done) begin
          issued_d = 1'b0;
          done_d   = !err_q;
          error_d  = err_q;
          state_d  = StIdle;
`ifdef EDID_CHECKSUM_EN
          if (!err_q) ok_d = (sum_q == 8'h00);
`endif
        end
      end
      default: begin
        issued_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // Command outputs: one pulse in the first cycle of each command state
  always_comb begin
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_write = 1'b0;
    cmd_read  = 1'b0;
    tx_byte   = 8'h00;
    ack_out   = 1'b0;
    unique case (state_q)
      StStart, StRStart: cmd_start = issue;
      StStopR, StStop:   cmd_stop  = issue;
      StDevW: begin
        cmd_write = issue;
        tx_byte   = issue ? DevWrite : 8'h00;
      end
      StOffs: begin
        cmd_write = issue;
        tx_byte   = issue ? offset_q : 8'h00;
      end
      StDevR: begin
        cmd_write = issue;
        tx_byte   = issue ? DevRead : 8'h00;
      end
      StRead: begin
        cmd_read = issue;
        ack_out  = issue && (cnt_q == LastCnt);
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;

`ifdef EDID_CHECKSUM_EN
  assign checksum_ok = ok_q;
`else
  assign checksum_ok = 1'b0;
`endif

endmodule

// File: doc/i2c_edid_reader_ctrl.md
Name: i2c_edid_reader_ctrl

Overview:
- I2C/DDC initiator-side protocol controller. It fetches an EDID block from a downstream sink, e.g. a monitor on the HDMI-out DDC lines.
- Sequences a byte-level I2C master engine through START, 0xA0, word offset, repeated START, 0xA1, N reads (ACK each, NACK the last), then STOP.
- Writes each received byte into local EDID RAM. Mirror of the EDID responder on the HDMI-in side.

Parameters:
- NUM_BYTES, 128, bytes read per transaction (1..256).
- MAX_RETRY, 3, device-address NACK retries before error (0..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle pulse; start read (ignored when busy=1).
- base_offset  in  8  EDID word offset sent to device (0x00 or 0x80).
- cmd_start  out  1  pulse: engine generates START/repeated START.
- cmd_stop  out  1  pulse: engine generates STOP.
- cmd_write  out  1  pulse: engine shifts out tx_byte, samples ACK.
- cmd_read  out  1  pulse: engine shifts in a byte, drives ack_out bit.
- tx_byte  out  8  byte to send; valid while cmd_write high.
- ack_out  out  1  ACK level for read (0=ACK, 1=NACK); valid while cmd_read high.
- cmd_done  in  1  engine pulse: current command finished.
- rx_byte  in  8  received byte; valid when cmd_done follows cmd_read.
- line_ack  in  1  sampled ACK after write (active-low); valid with cmd_done.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  8  RAM address.
- mem_wdata  out  8  RAM data.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse: successful completion.
- error  out  1  one-cycle pulse: aborted on NACK.
- checksum_ok  out  1  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, retry counter 0, byte counter 0.
- Every cmd_*, mem_we, done and error output is a single-cycle pulse. The controller issues exactly one command, then waits for cmd_done before issuing the next. cmd_done outside a wait state is ignored.
- IDLE:
  - go=1 latches base_offset, clears counters, sets busy, then goes to S_START.
- S_START:
  - Pulse cmd_start; on cmd_done go to S_DEVW.
- S_DEVW:
  - Pulse cmd_write with tx_byte=0xA0.
  - On cmd_done with line_ack=0, go to S_OFFS.
  - On cmd_done with line_ack=1: if retry<MAX_RETRY, increment retry and go to S_STOPR (STOP, then S_START). Otherwise set err flag and go to S_STOP.
- S_OFFS:
  - cmd_write with tx_byte=latched offset.
  - NACK sets err flag, then S_STOP. ACK goes to S_RSTART.
- S_RSTART:
  - cmd_start (repeated START); on cmd_done go to S_DEVR.
- S_DEVR:
  - cmd_write with tx_byte=0xA1.
  - NACK sets err flag, then S_STOP. ACK goes to S_READ.
- S_READ:
  - cmd_read with ack_out = (cnt==NUM_BYTES-1).
  - On cmd_done, mem_we=1 in the next cycle with mem_addr=cnt[7:0] and mem_wdata=rx_byte; cnt increments.
  - After the last byte, go to S_STOP.
- S_STOP:
  - cmd_stop; on cmd_done, pulse done (err flag=0) or error (err flag=1), clear busy, return to IDLE.
- Address/counter widths:
  - cnt is 9 bits so NUM_BYTES=256 terminates.
  - mem_addr is cnt relative to 0: byte k goes to RAM address k, independent of base_offset.
  - The device's offset wraps at 0xFF on its own side; no local wrap handling.
- go while busy=1: ignored, no effect.
- Reset mid-transaction: immediate return to IDLE, no STOP issued. The engine is reset by the same rst_n.
- The retry counter resets only on go.

Optional Feature:
- Macro: EDID_CHECKSUM_EN.
- Defined:
  - Accumulate an 8-bit modulo-256 sum of all bytes written.
  - At done, checksum_ok = (sum==0) and holds until the next go, which clears it to 0.
  - A checksum failure does not pulse error.
- Undefined:
  - No accumulator is built; checksum_ok is tied to 0.

Test Plan:
- Happy path: go, base_offset=0x00, NUM_BYTES=128, device ACKs all. Expect write sequence 0xA0, 0x00, 0xA1, 128 reads with ack_out=0 on reads 0..126 and 1 on read 127, 128 mem_we with addr 0..127 matching the model, one STOP, done=1, error=0.
- Offset 0x80: go with base_offset=0x80. Expect second tx_byte 0x80; RAM addresses still 0..127.
- Retry: device NACKs 0xA0 twice, then ACKs, MAX_RETRY=3. Expect START/0xA0/STOP repeated 2 times, then a full transfer and done.
- Retry exhaustion: device NACKs 0xA0 forever, MAX_RETRY=3. Expect 4 address attempts, final STOP, error=1, no mem_we.
- Reset mid-read: rst_n low after 50 bytes. Expect all outputs 0 immediately and busy=0; a subsequent go performs a full transfer.
- Checksum (EDID_CHECKSUM_EN): 128 bytes summing to 0x00 gives checksum_ok=1; corrupt byte 5 by +1 gives checksum_ok=0 with done=1.
